// File: rtl/sec_code_pkg.sv
// sec_code_pkg: shared SECDED code definitions for the 32-bit encoder and the decoder model.
//   DATA_W/CHK_W/CW_W : data, check and codeword widths.
//   P                 : codeword position of each data bit (integers >= 3, powers of two skipped).
//   CHK_MASK          : per-check-bit mask over the data word; bit 6 folds in the overall parity.
//   calc_chk          : full check-bit computation.
//   byte_partial      : check-bit contribution of one data byte (XOR of these equals calc_chk).
package sec_code_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned CHK_W     = 7;
   localparam int unsigned CW_W      = 39;
   localparam int unsigned NUM_BYTES = 4;

   typedef logic [5:0] pos_t;

   localparam pos_t P [DATA_W] = '{
      6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
      6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
      6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
      6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
   };

   typedef logic [CHK_W-1:0][DATA_W-1:0] chk_mask_t;

   // chk[6] = ^data ^ ^chk[5:0]; a data bit therefore lands in chk[6] exactly when
   // its position has an even number of set bits.
   function automatic chk_mask_t build_chk_mask();
      chk_mask_t m;
      m = '0;
      for (int j = 0; j < DATA_W; j++) begin
         for (int i = 0; i < 6; i++) begin
            m[i][j] = P[j][i];
         end
         m[6][j] = ~(^P[j]);
      end
      return m;
   endfunction

   localparam chk_mask_t CHK_MASK = build_chk_mask();

   function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] data);
      logic [CHK_W-1:0] chk;
      for (int i = 0; i < CHK_W; i++) begin
         chk[i] = ^(data & CHK_MASK[i]);
      end
      return chk;
   endfunction

   function automatic logic [CHK_W-1:0] byte_partial(input logic [7:0] bval,
                                                     input int unsigned b);
      logic [CHK_W-1:0] part;
      for (int i = 0; i < CHK_W; i++) begin
         part[i] = ^(bval & CHK_MASK[i][b*8 +: 8]);
      end
      return part;
   endfunction

endpackage

// File: rtl/sec_pipe_stage.sv
// sec_pipe_stage: one valid/ready register slice.
//   clk, rst_n          : clock, asynchronous active-low reset.
//   in_valid/in_ready   : upstream handshake, in_data captured on transfer.
//   out_valid/out_ready : downstream handshake, out_data held while stalled.
// Loads when empty or when its current content leaves in the same cycle.
module sec_pipe_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;

   assign in_ready  = !full_q || out_ready;
   assign out_valid = full_q;
   assign out_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         if (in_ready) begin
            full_q <= in_valid;
         end
         if (in_valid && in_ready) begin
            data_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/sec_check_encoder.sv
// sec_check_encoder: SECDED (39,32) check-bit generator with valid/ready pipeline.
//   clk, rst_n                   : clock, asynchronous active-low reset.
//   in_valid/in_ready/in_data    : 32-bit data word input handshake.
//   out_valid/out_ready          : codeword output handshake.
//   out_data/out_chk             : codeword data field and 7 check bits.
//   word_cnt                     : saturating count of codewords taken by the sink.
//   inj_arm/inj_mask             : one-shot error injection, mask order {chk,data}.
// Optional feature macro: SEC_ENC_ERR_INJECT_EN (injection logic built only when defined).
// PIPE_STAGES = 2: stage 1 holds data plus per-byte partial check vectors, stage 2 holds the
// combined codeword. PIPE_STAGES = 1: single stage holding the full codeword.
module sec_check_encoder
   import sec_code_pkg::*;
#(
   parameter int unsigned PIPE_STAGES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [6:0]        out_chk,
   output logic [CNT_W-1:0]  word_cnt,
   input  logic              inj_arm,
   input  logic [38:0]       inj_mask
);

   logic [CW_W-1:0] cw_out;
   logic [CW_W-1:0] cw_final;
   logic            cw_valid;
   logic            out_fire;

   if (PIPE_STAGES == 1) begin : g_single
      sec_pipe_stage #(.WIDTH(CW_W)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .in_data  ({calc_chk(in_data), in_data}),
         .out_valid(cw_valid),
         .out_ready(out_ready),
         .out_data (cw_out)
      );
   end else begin : g_double
      localparam int unsigned S1_W = DATA_W + NUM_BYTES * CHK_W;

      logic [S1_W-1:0]  s1_in;
      logic [S1_W-1:0]  s1_out;
      logic             s1_valid;
      logic             s1_ready;
      logic [CHK_W-1:0] chk_comb;

      // Stage-1 payload: {partial[3], .., partial[0], data}.
      always_comb begin
         s1_in = '0;
         s1_in[DATA_W-1:0] = in_data;
         for (int b = 0; b < NUM_BYTES; b++) begin
            s1_in[DATA_W + b*CHK_W +: CHK_W] = byte_partial(in_data[b*8 +: 8], b);
         end
      end

      // The code is linear, so the full check vector is the XOR of the byte partials.
      always_comb begin
         chk_comb = '0;
         for (int b = 0; b < NUM_BYTES; b++) begin
            chk_comb = chk_comb ^ s1_out[DATA_W + b*CHK_W +: CHK_W];
         end
      end

      sec_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .in_data  (s1_in),
         .out_valid(s1_valid),
         .out_ready(s1_ready),
         .out_data (s1_out)
      );

      sec_pipe_stage #(.WIDTH(CW_W)) u_stage2 (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (s1_valid),
         .in_ready (s1_ready),
         .in_data  ({chk_comb, s1_out[DATA_W-1:0]}),
         .out_valid(cw_valid),
         .out_ready(out_ready),
         .out_data (cw_out)
      );
   end

   assign out_fire = cw_valid && out_ready;

`ifdef SEC_ENC_ERR_INJECT_EN
   logic            inj_armed_q;
   logic [CW_W-1:0] inj_mask_q;

   // A new arm takes priority over the disarm of a concurrent handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_armed_q <= 1'b0;
         inj_mask_q  <= '0;
      end else if (inj_arm) begin
         inj_armed_q <= 1'b1;
         inj_mask_q  <= inj_mask;
      end else if (out_fire) begin
         inj_armed_q <= 1'b0;
      end
   end

   assign cw_final = (inj_armed_q && cw_valid) ? (cw_out ^ inj_mask_q) : cw_out;
`else
   logic unused_inj;
   assign unused_inj = ^{inj_arm, inj_mask};
   assign cw_final   = cw_out;
`endif

   assign out_valid = cw_valid;
   assign out_data  = cw_final[DATA_W-1:0];
   assign out_chk   = cw_final[CW_W-1:DATA_W];

   logic [CNT_W-1:0] word_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q <= '0;
      end else if (out_fire && (word_cnt_q != '1)) begin
         word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
   end

   assign word_cnt = word_cnt_q;

endmodule
